// File: rtl/pc_redirect_pkg.sv
// Shared CPU definitions for the fetch-address redirect block.
// Holds the state encoding, PC step and branch-counter width.
package pc_redirect_pkg;

    localparam int          CNT_W   = 16;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_redirect_if.sv
// Branch/jump resolution inputs and fetch-side outputs of pc_redirect.
// slave = the redirect block, master = the pipeline driving it.
interface pc_redirect_if;
    import pc_redirect_pkg::*;

    logic             stall;
    logic             br_valid;
    logic             bcres;
    logic [31:0]      br_target;
    logic             jmp_valid;
    logic [31:0]      jmp_target;
    logic [31:0]      pc;
    logic             pc_valid;
    logic             flush;
    logic             misalign;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] ntaken_cnt;

    modport slave (
        input  stall, br_valid, bcres, br_target, jmp_valid, jmp_target,
        output pc, pc_valid, flush, misalign, taken_cnt, ntaken_cnt
    );

    modport master (
        output stall, br_valid, bcres, br_target, jmp_valid, jmp_target,
        input  pc, pc_valid, flush, misalign, taken_cnt, ntaken_cnt
    );
endinterface

// File: rtl/sat_counter16.sv
// Enable-driven up counter that sticks at all-ones instead of wrapping.
module sat_counter16
    import pc_redirect_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pc_redirect.sv
// Fetch PC generator: sequential fetch, branch/jump redirect with a fixed
// wrong-path squash window, misaligned-target trap and branch statistics.
module pc_redirect
    import pc_redirect_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    pc_redirect_if.slave  bus
);

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [2:0]  fcnt_reg, fcnt_next;
    logic        misalign_reg, misalign_next;

    logic        run_go;
    logic        redirect;
    logic [31:0] target;
    logic [1:0]  cnt_en;
    logic [CNT_W-1:0] cnt_val [2];

    // Branch outcomes only count while RUN actually advances.
    assign run_go   = (state_reg == RUN) && !bus.stall;
    assign redirect = run_go && (bus.jmp_valid || (bus.br_valid && bus.bcres));
    assign target   = bus.jmp_valid ? bus.jmp_target : bus.br_target;
    assign cnt_en[0] = run_go && bus.br_valid &&  bus.bcres;
    assign cnt_en[1] = run_go && bus.br_valid && !bus.bcres;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= BOOT;
            pc_reg       <= RESET_PC;
            fcnt_reg     <= '0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            fcnt_reg     <= fcnt_next;
            misalign_reg <= misalign_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BOOT:    state_next = RUN;
            RUN:     if (redirect) state_next = FLUSH;
            FLUSH:   if (fcnt_reg == 3'd0) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    // fcnt counts down the remaining squash cycles, last one at zero.
    always_comb begin
        pc_next       = pc_reg;
        fcnt_next     = fcnt_reg;
        misalign_next = 1'b0;
        if (redirect) begin
            pc_next       = is_misaligned(target) ? TRAP_VEC : target;
            misalign_next = is_misaligned(target);
            fcnt_next     = FLUSH_LAST;
        end else if (run_go) begin
            pc_next = pc_reg + PC_STEP;
        end else if (state_reg == FLUSH) begin
            pc_next = pc_reg + PC_STEP;
            if (fcnt_reg != 3'd0) begin
                fcnt_next = fcnt_reg - 3'd1;
            end
        end
    end

    always_comb begin
        bus.pc       = pc_reg;
        bus.pc_valid = (state_reg != BOOT);
        bus.flush    = (state_reg == FLUSH);
        bus.misalign = misalign_reg;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            sat_counter16 u_cnt (
                .clk   (clk),
                .rst   (rst),
                .en    (cnt_en[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign bus.taken_cnt  = cnt_val[0];
    assign bus.ntaken_cnt = cnt_val[1];

endmodule

// File: tb/tb_pc_redirect.sv
// Directed and randomized bench for pc_redirect against a cycle-level
// behavioural model of the fetch/redirect rules.
module tb_pc_redirect;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP   = 32'h0000_0100;
    localparam int          FC     = 2;

    logic clk = 1'b0;
    logic rst;
    logic sat_en;
    logic [15:0] sat_count;

    always #5 clk = ~clk;

    pc_redirect_if bus ();

    pc_redirect #(.RESET_PC(RST_PC), .TRAP_VEC(TRAP), .FLUSH_CYCLES(FC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sat_counter16 u_sat (
        .clk   (clk),
        .rst   (rst),
        .en    (sat_en),
        .count (sat_count)
    );

    int checks = 0;
    int errors = 0;

    // Model: mode 0 = boot, 1 = run, 2 = squashing wrong path
    int          m_mode;
    logic [31:0] m_pc;
    int          m_left;
    bit          m_mis;
    int          m_tc, m_nc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = RST_PC; m_left = 0; m_mis = 0; m_tc = 0; m_nc = 0;
    endtask

    task automatic model_step();
        logic [31:0] t;
        m_mis = 0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 2) begin
            m_pc = m_pc + 32'd4;
            m_left--;
            if (m_left == 0) m_mode = 1;
        end else if (!bus.stall) begin
            if (bus.br_valid) begin
                if (bus.bcres) m_tc = (m_tc < 65535) ? m_tc + 1 : 65535;
                else           m_nc = (m_nc < 65535) ? m_nc + 1 : 65535;
            end
            if (bus.jmp_valid || (bus.br_valid && bus.bcres)) begin
                t = bus.jmp_valid ? bus.jmp_target : bus.br_target;
                if (t % 4 != 0) begin
                    m_pc  = TRAP;
                    m_mis = 1;
                end else begin
                    m_pc = t;
                end
                m_mode = 2;
                m_left = FC;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check_all();
        check("pc",         bus.pc,                m_pc);
        check("pc_valid",   32'(bus.pc_valid),     32'(m_mode != 0));
        check("flush",      32'(bus.flush),        32'(m_mode == 2));
        check("misalign",   32'(bus.misalign),     32'(m_mis));
        check("taken_cnt",  32'(bus.taken_cnt),    32'(m_tc));
        check("ntaken_cnt", 32'(bus.ntaken_cnt),   32'(m_nc));
    endtask

    task automatic idle_inputs();
        bus.stall = 0; bus.br_valid = 0; bus.bcres = 0; bus.jmp_valid = 0;
        bus.br_target = 32'h0; bus.jmp_target = 32'h0;
    endtask

    task automatic cycle(input bit show);
        @(posedge clk);
        model_step();
        #1;
        if (show) begin
            check_all();
            $display("cyc pc=%h v=%b fl=%b mis=%b tc=%0d nc=%0d",
                     bus.pc, bus.pc_valid, bus.flush, bus.misalign, bus.taken_cnt, bus.ntaken_cnt);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        sat_en = 1'b0;
        apply_reset();

        // Boot: one invalid cycle at RESET_PC, then 0,4,8,C,10
        for (int i = 0; i < 5; i++) cycle(1);
        check("boot_pc", bus.pc, 32'h10);

        // Taken branch with ignored wrong-path branch
        bus.br_valid = 1; bus.bcres = 1; bus.br_target = 32'h40;
        cycle(1);
        check("tb_pc", bus.pc, 32'h40);
        check("tb_flush", 32'(bus.flush), 32'd1);
        bus.br_target = 32'h80;
        cycle(1);
        check("tb_flush_pc", bus.pc, 32'h44);
        idle_inputs();
        cycle(1);
        check("tb_done_pc", bus.pc, 32'h48);
        check("tb_done_flush", 32'(bus.flush), 32'd0);
        check("tb_taken", 32'(bus.taken_cnt), 32'd1);

        // Not-taken, then stall with a taken branch presented
        bus.br_valid = 1; bus.bcres = 0;
        cycle(1);
        check("nt_pc", bus.pc, 32'h4C);
        check("nt_cnt", 32'(bus.ntaken_cnt), 32'd1);
        bus.stall = 1; bus.bcres = 1; bus.br_target = 32'h80;
        for (int i = 0; i < 3; i++) cycle(1);
        check("stall_pc", bus.pc, 32'h4C);
        check("stall_flush", 32'(bus.flush), 32'd0);
        idle_inputs();
        cycle(1);
        check("unstall_pc", bus.pc, 32'h50);

        // Jump beats branch; misaligned jump target traps
        bus.jmp_valid = 1; bus.jmp_target = 32'h202;
        bus.br_valid = 1; bus.bcres = 1; bus.br_target = 32'h80;
        cycle(1);
        check("mis_pc", bus.pc, 32'h100);
        check("mis_pulse", 32'(bus.misalign), 32'd1);
        check("mis_taken", 32'(bus.taken_cnt), 32'd2);
        idle_inputs();
        cycle(1);
        check("mis_clear", 32'(bus.misalign), 32'd0);
        cycle(1);

        // Address wrap
        bus.jmp_valid = 1; bus.jmp_target = 32'hFFFF_FFF8;
        cycle(1);
        idle_inputs();
        cycle(1);
        check("wrap_hi", bus.pc, 32'hFFFF_FFFC);
        cycle(1);
        check("wrap_zero", bus.pc, 32'h0);

        // Reset on the first flush cycle
        bus.jmp_valid = 1; bus.jmp_target = 32'h300;
        cycle(1);
        idle_inputs();
        apply_reset();
        check("rmf_flush", 32'(bus.flush), 32'd0);
        check("rmf_pc", bus.pc, RST_PC);
        cycle(1);
        check("rmf_boot_pc", bus.pc, RST_PC);
        check("rmf_valid", 32'(bus.pc_valid), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.stall      = ($urandom_range(0, 3) == 0);
            bus.br_valid   = ($urandom_range(0, 2) == 0);
            bus.bcres      = $urandom_range(0, 1);
            bus.jmp_valid  = ($urandom_range(0, 7) == 0);
            bus.br_target  = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : 32'd0);
            bus.jmp_target = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : 32'd0);
            cycle(1);
        end

        // Saturation: not-taken counter in the block, standalone counter alongside
        bus.stall = 0; bus.jmp_valid = 0; bus.br_valid = 1; bus.bcres = 0;
        @(negedge clk);
        sat_en = 1'b1;
        for (int i = 0; i < 65540; i++) cycle(0);
        check_all();
        check("sat_ntaken", 32'(bus.ntaken_cnt), 32'hFFFF);
        check("sat_counter", 32'(sat_count), 32'hFFFF);
        for (int i = 0; i < 4; i++) cycle(0);
        check("sat_counter_hold", 32'(sat_count), 32'hFFFF);
        sat_en = 1'b0;
        idle_inputs();
        bus.br_valid = 1; bus.bcres = 1; bus.br_target = 32'h1000;
        cycle(1);
        idle_inputs();
        for (int i = 0; i < 4; i++) cycle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_redirect.md
PC_REDIRECT -- requirements
Module: pc_redirect

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: the fetch address after reset.
REQ-002 The block SHALL have parameter TRAP_VEC, default 32'h0000_0100: the redirect address for a misaligned target.
REQ-003 The block SHALL have parameter FLUSH_CYCLES, default 2, legal range 1..7: the number of wrong-path squash cycles.
REQ-004 Port: clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous, active-high.
REQ-006 Port: stall  in  1  pipeline stall; holds the PC in RUN.
REQ-007 Port: br_valid  in  1  conditional branch resolving in EX this cycle.
REQ-008 Port: bcres  in  1  branch condition result from the condition evaluator; 1 = taken.
REQ-009 Port: br_target  in  32  branch target address.
REQ-010 Port: jmp_valid  in  1  unconditional jump resolving this cycle.
REQ-011 Port: jmp_target  in  32  jump target address.
REQ-012 Port: pc  out  32  current fetch address (registered).
REQ-013 Port: pc_valid  out  1  pc is a valid fetch request.
REQ-014 Port: flush  out  1  squash IF/ID wrong-path instructions.
REQ-015 Port: misalign  out  1  single-cycle pulse: redirect target had [1:0] != 0.
REQ-016 Port: taken_cnt  out  16  count of taken conditional branches.
REQ-017 Port: ntaken_cnt  out  16  count of not-taken conditional branches.

Function
REQ-018 The state machine SHALL have states BOOT, RUN and FLUSH; BOOT SHALL last exactly one cycle and then go to RUN.
REQ-019 pc_valid SHALL be 0 in BOOT and 1 in RUN and FLUSH.
REQ-020 In RUN with stall=0 and no redirect, pc SHALL advance by 4 per cycle, mod 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-021 In RUN with stall=1, pc, state and counters SHALL hold, and br_valid/jmp_valid SHALL be ignored.
REQ-022 A redirect SHALL occur in RUN with stall=0 when jmp_valid=1, or when br_valid=1 and bcres=1; jmp_valid SHALL take priority over br_valid.
REQ-023 On a redirect edge, pc SHALL load the selected target, or TRAP_VEC if target[1:0] != 0; state SHALL become FLUSH.
REQ-024 The misalign output SHALL be 1 for exactly the cycle after a misaligned redirect edge, and 0 otherwise.
REQ-025 flush SHALL be 1 for exactly FLUSH_CYCLES cycles, starting the cycle after the redirect edge; state SHALL return to RUN in the cycle after the last flush cycle.
REQ-026 In FLUSH, pc SHALL advance by 4 per cycle regardless of stall; br_valid and jmp_valid SHALL be ignored (wrong path); counters SHALL not change.
REQ-027 In RUN with stall=0 and br_valid=1 (with or without jmp_valid), taken_cnt SHALL increment if bcres=1, else ntaken_cnt SHALL increment.
REQ-028 Both counters SHALL saturate at 16'hFFFF.
REQ-029 br_valid=1 with bcres=0 SHALL NOT redirect; pc+4 SHALL continue.

Reset
REQ-030 While rst=1, the block SHALL set pc=RESET_PC, pc_valid=0, flush=0, misalign=0, taken_cnt=0, ntaken_cnt=0 and state=BOOT, independent of clk.
REQ-031 Reset asserted mid-FLUSH SHALL abort the flush immediately; after release, one BOOT cycle SHALL precede fetch from RESET_PC.

Structure
REQ-032 The state enumeration, the PC step constant (4) and the counter width (16) SHALL live in the shared CPU package.
REQ-033 The block SHALL instantiate one sub-module, sat_counter16 (enable, async active-high reset, saturating), twice: taken and not-taken.

Verification
REQ-034 Reset/boot: release rst at RESET_PC=0 -> pc=0 with pc_valid=0 for 1 cycle, then pc=0,4,8 with pc_valid=1.
REQ-035 Taken branch: at pc=0x10, br_valid=1, bcres=1, br_target=0x40 -> pc=0x40, flush=1 for 2 cycles (pc 0x40, 0x44), taken_cnt=1; a br_valid pulse during flush is ignored.
REQ-036 Not-taken plus stall: br_valid=1, bcres=0 -> no flush, pc+4, ntaken_cnt=1; stall=1 for 3 cycles -> pc constant and a taken branch presented during the stall does not redirect.
REQ-037 Priority/misalign: jmp_valid=1, jmp_target=0x202, br_valid=1, bcres=1, br_target=0x80 -> pc=0x100 (TRAP_VEC), misalign=1 for 1 cycle, taken_cnt+1.
REQ-038 Wrap/saturation: jump to 0xFFFF_FFF8 -> pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; force 65536 taken branches -> taken_cnt stays 0xFFFF.
REQ-039 Reset mid-flush: rst asserted on the first flush cycle -> flush=0 immediately; after release pc restarts at RESET_PC via BOOT.
